// File: rtl/encoder_4to2_sf.sv
// Registered 4-to-2 encoder with sample enable, multi-hot rejection and a saturating reject counter.
// Define ENCODER_4TO2_SF_PRIORITY_EN to encode multi-hot inputs by their highest set bit instead of rejecting them.
module encoder_4to2_sf #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3:0]           d,
    output logic [1:0]           o,
    output logic                 valid,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef struct packed {
        logic       zero;
        logic       one_hot;
        logic [1:0] code;
    } dec_t;

    dec_t dec;

    // The code is the highest set bit, which is also the unique bit when d is one-hot.
    always_comb begin
        dec         = '0;
        dec.zero    = (d == 4'b0000);
        dec.one_hot = !dec.zero && ((d & (d - 4'd1)) == 4'b0000);
        if (d[3])      dec.code = 2'd3;
        else if (d[2]) dec.code = 2'd2;
        else if (d[1]) dec.code = 2'd1;
        else           dec.code = 2'd0;
    end

    logic accept;
`ifdef ENCODER_4TO2_SF_PRIORITY_EN
    assign accept = !dec.zero;
`else
    assign accept = dec.one_hot;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o       <= 2'b00;
            valid   <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (en) begin
            if (dec.zero) begin
                valid <= 1'b0;
                err   <= 1'b0;
            end else if (accept) begin
                o     <= dec.code;
                valid <= 1'b1;
                err   <= 1'b0;
            end else begin
                // Rejected multi-hot sample: o keeps its last good code.
                valid <= 1'b0;
                err   <= 1'b1;
                if (err_cnt != {ERR_CNT_W{1'b1}})
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encoder_4to2_sf.sv
// Directed bench for encoder_4to2_sf: a default-width and a 2-bit-counter instance share stimulus; a scoreboard holds expectations.
module tb_encoder_4to2_sf;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] d;

    logic [1:0] o,  o_s;
    logic       valid, valid_s, err, err_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;

    encoder_4to2_sf u_dut (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .o(o), .valid(valid), .err(err), .err_cnt(err_cnt)
    );

    encoder_4to2_sf #(.ERR_CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .d(d),
        .o(o_s), .valid(valid_s), .err(err_s), .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] o;
        logic       v;
        logic       e;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t sb[$];

`ifdef ENCODER_4TO2_SF_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    // Reference state
    logic [1:0] m_o;
    logic       m_v, m_e;
    logic [7:0] m_c8;
    logic [1:0] m_c2;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_chk++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model(input logic r, input logic e_in, input logic [3:0] din);
        int hi;
        hi = 0;
        for (int i = 0; i < 4; i++) if (din[i]) hi = i;
        if (r) begin
            m_o = 2'b00; m_v = 1'b0; m_e = 1'b0; m_c8 = 8'd0; m_c2 = 2'd0;
        end else if (e_in) begin
            if (din == 4'b0000) begin
                m_v = 1'b0; m_e = 1'b0;
            end else if ($countones(din) == 1 || PRIO) begin
                m_o = 2'(hi); m_v = 1'b1; m_e = 1'b0;
            end else begin
                m_v = 1'b0; m_e = 1'b1;
                if (m_c8 != 8'hff) m_c8 = m_c8 + 8'd1;
                if (m_c2 != 2'b11) m_c2 = m_c2 + 2'd1;
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic e_in, input logic [3:0] din);
        exp_t x;
        rst = r; en = e_in; d = din;
        model(r, e_in, din);
        x.tag = tag; x.o = m_o; x.v = m_v; x.e = m_e; x.c8 = m_c8; x.c2 = m_c2;
        sb.push_back(x);
        n_vec++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            x = sb.pop_front();
            chk({x.tag, "_o"},       {6'd0, o},       {6'd0, x.o});
            chk({x.tag, "_valid"},   {7'd0, valid},   {7'd0, x.v});
            chk({x.tag, "_err"},     {7'd0, err},     {7'd0, x.e});
            chk({x.tag, "_cnt"},     err_cnt,         x.c8);
            chk({x.tag, "_o_s"},     {6'd0, o_s},     {6'd0, x.o});
            chk({x.tag, "_cnt_sat"}, {6'd0, err_cnt_s}, {6'd0, x.c2});
            chk({x.tag, "_excl"},    {7'd0, valid & err}, 8'd0);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; d = 4'b0000;
        m_o = 2'b00; m_v = 1'b0; m_e = 1'b0; m_c8 = 8'd0; m_c2 = 2'd0;
        @(posedge clk);
        #1;

        step("reset", 1'b1, 1'b1, 4'b1111);

        // one-hot sweep
        step("oh0", 1'b0, 1'b1, 4'b0001);
        step("oh1", 1'b0, 1'b1, 4'b0010);
        step("oh2", 1'b0, 1'b1, 4'b0100);
        step("oh3", 1'b0, 1'b1, 4'b1000);

        // zero input holds o
        step("pre_zero", 1'b0, 1'b1, 4'b0100);
        step("zero",     1'b0, 1'b1, 4'b0000);

        // multi-hot
        step("multi_a",  1'b0, 1'b1, 4'b1010);
        step("multi_b",  1'b0, 1'b1, 4'b0110);

        // enable hold
        step("hold0", 1'b0, 1'b0, 4'b0001);
        step("hold1", 1'b0, 1'b0, 4'b1000);
        step("hold_release", 1'b0, 1'b1, 4'b0001);
        step("hold_after_err", 1'b0, 1'b1, 4'b0011);
        step("hold2", 1'b0, 1'b0, 4'b0100);

        // saturation run
        for (int i = 0; i < 6; i++)
            step($sformatf("sat%0d", i), 1'b0, 1'b1, (i % 2) ? 4'b1111 : 4'b0101);
        step("sat_idle", 1'b0, 1'b1, 4'b0000);
        step("sat_more", 1'b0, 1'b1, 4'b1100);

        // reset mid-stream, during saturation
        step("rst_mid",   1'b1, 1'b1, 4'b1000);
        step("post_rst",  1'b0, 1'b1, 4'b0010);
        step("post_rst2", 1'b0, 1'b1, 4'b1001);

        if (sb.size() != 0) chk("sb_leftover", 8'(sb.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
